// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IF_REQ_pi;
    logic [ADDR_W-1:0] IF_ADDR_pi;
    logic [DATA_W-1:0] IF_RDATA_po;
    logic              IF_DONE_po;
    logic              IF_STALL_po;
    logic              D_REQ_pi;
    logic              D_WE_pi;
    logic [ADDR_W-1:0] D_ADDR_pi;
    logic [DATA_W-1:0] D_WDATA_pi;
    logic [DATA_W-1:0] D_RDATA_po;
    logic              D_DONE_po;
    logic              D_STALL_po;
    logic              MEM_REQ_po;
    logic              MEM_WE_po;
    logic [ADDR_W-1:0] MEM_ADDR_po;
    logic [DATA_W-1:0] MEM_WDATA_po;
    logic [DATA_W-1:0] MEM_RDATA_pi;
    logic              MEM_ACK_pi;
    logic              ERR_po;

    modport master (
        input  IF_REQ_pi, IF_ADDR_pi, D_REQ_pi, D_WE_pi, D_ADDR_pi, D_WDATA_pi,
               MEM_RDATA_pi, MEM_ACK_pi,
        output IF_RDATA_po, IF_DONE_po, IF_STALL_po, D_RDATA_po, D_DONE_po, D_STALL_po,
               MEM_REQ_po, MEM_WE_po, MEM_ADDR_po, MEM_WDATA_po, ERR_po
    );

    modport slave (
        output IF_REQ_pi, IF_ADDR_pi, D_REQ_pi, D_WE_pi, D_ADDR_pi, D_WDATA_pi,
               MEM_RDATA_pi, MEM_ACK_pi,
        input  IF_RDATA_po, IF_DONE_po, IF_STALL_po, D_RDATA_po, D_DONE_po, D_STALL_po,
               MEM_REQ_po, MEM_WE_po, MEM_ADDR_po, MEM_WDATA_po, ERR_po
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for the unified single-port memory
// ARB_ROUND_ROBIN_EN selects round-robin grant; default build uses fixed data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               CLK_pi,
    input  logic               CPU_RESET_pi,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic              own_ls_q, own_ls_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              busy;
    logic              timeout_hit;
    logic              grant_ls;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_ls_q, last_ls_d;
`endif

    always_comb begin
        state_d    = state_q;
        own_ls_d   = own_ls_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        wd_cnt_d   = wd_cnt_q;
        busy        = (state_q == BUSY_IF) || (state_q == BUSY_D);
        timeout_hit = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);
`ifdef ARB_ROUND_ROBIN_EN
        last_ls_d  = last_ls_q;
        grant_ls   = bus.D_REQ_pi && (!bus.IF_REQ_pi || !last_ls_q);
`else
        grant_ls   = bus.D_REQ_pi;
`endif

        case (state_q)
            IDLE: begin
                if (bus.IF_REQ_pi || bus.D_REQ_pi) begin
                    own_ls_d = grant_ls;
                    we_d     = grant_ls && bus.D_WE_pi;
                    addr_d   = grant_ls ? bus.D_ADDR_pi : bus.IF_ADDR_pi;
                    wdata_d  = grant_ls ? bus.D_WDATA_pi : '0;
                    err_d    = 1'b0;
                    wd_cnt_d = '0;
                    state_d  = grant_ls ? BUSY_D : BUSY_IF;
`ifdef ARB_ROUND_ROBIN_EN
                    last_ls_d = grant_ls;
`endif
                end
            end
            BUSY_IF, BUSY_D: begin
                // An ack on the watchdog's final cycle still completes the access cleanly.
                if (bus.MEM_ACK_pi) begin
                    if (!own_ls_q) begin
                        if_rdata_d = bus.MEM_RDATA_pi;
                    end else if (!we_q) begin
                        d_rdata_d = bus.MEM_RDATA_pi;
                    end
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                    if (!own_ls_q) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                    state_d = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Memory-side attributes are only meaningful while the request is up.
        if (busy && state_d == RESP) begin
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge CLK_pi or posedge CPU_RESET_pi) begin
        if (CPU_RESET_pi) begin
            state_q    <= IDLE;
            own_ls_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            wd_cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            own_ls_q   <= own_ls_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            wd_cnt_q   <= wd_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_q  <= last_ls_d;
`endif
        end
    end

    assign bus.MEM_REQ_po   = busy;
    assign bus.MEM_WE_po    = we_q;
    assign bus.MEM_ADDR_po  = addr_q;
    assign bus.MEM_WDATA_po = wdata_q;
    assign bus.IF_RDATA_po  = if_rdata_q;
    assign bus.D_RDATA_po   = d_rdata_q;
    assign bus.IF_DONE_po   = (state_q == RESP) && !own_ls_q;
    assign bus.D_DONE_po    = (state_q == RESP) && own_ls_q;
    assign bus.ERR_po       = (state_q == RESP) && err_q;
    assign bus.IF_STALL_po  = bus.IF_REQ_pi && !bus.IF_DONE_po;
    assign bus.D_STALL_po   = bus.D_REQ_pi && !bus.D_DONE_po;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with randomized requesters and memory
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK_pi       (clk),
        .CPU_RESET_pi (rst),
        .bus          (bus)
    );

    typedef struct { logic own_ls; logic [31:0] if_rdata; logic [31:0] d_rdata; logic err; } done_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int len; } attr_t;
    typedef struct { int delay; logic [31:0] rdata; } mem_t;

    done_t done_q[$];
    attr_t attr_q[$];
    mem_t  mem_q[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata  = '0;
`ifdef ARB_ROUND_ROBIN_EN
    logic        m_last_d   = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one access in service order; delay < 0 means memory never acks.
    task automatic model_access(input logic ls, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
        attr_t a;
        done_t d;
        mem_t  m;
        logic  tout;
        tout    = (delay < 0);
        a.we    = ls & we;
        a.addr  = addr;
        a.wdata = ls ? wdata : 32'h0;
        a.len   = tout ? TIMEOUT : delay + 1;
        if (tout) begin
            if (ls) m_d_rdata = '0; else m_if_rdata = '0;
        end else if (!ls) begin
            m_if_rdata = rdata;
        end else if (!we) begin
            m_d_rdata = rdata;
        end
        d.own_ls   = ls;
        d.if_rdata = m_if_rdata;
        d.d_rdata  = m_d_rdata;
        d.err      = tout;
        m.delay    = delay;
        m.rdata    = rdata;
        attr_q.push_back(a);
        done_q.push_back(d);
        mem_q.push_back(m);
`ifdef ARB_ROUND_ROBIN_EN
        m_last_d = ls;
`endif
    endtask

    task automatic run_batch(input bit ife, input bit de, input logic [31:0] ia, input bit we,
                             input logic [31:0] da, input logic [31:0] wd,
                             input int if_dly, input logic [31:0] if_rd,
                             input int d_dly, input logic [31:0] d_rd);
        bit first_ls;
        int first_dly;
        int n;
        bit if_pend;
        bit d_pend;
        bit first_seen;
        if (ife && de) begin
`ifdef ARB_ROUND_ROBIN_EN
            first_ls = !m_last_d;
`else
            first_ls = 1'b1;
`endif
        end else begin
            first_ls = de;
        end
        if (first_ls) begin
            model_access(1'b1, we, da, wd, d_dly, d_rd);
            if (ife) model_access(1'b0, 1'b0, ia, 32'h0, if_dly, if_rd);
        end else begin
            model_access(1'b0, 1'b0, ia, 32'h0, if_dly, if_rd);
            if (de) model_access(1'b1, we, da, wd, d_dly, d_rd);
        end
        first_dly = first_ls ? d_dly : if_dly;

        bus.IF_ADDR_pi  = ia;
        bus.D_WE_pi     = we;
        bus.D_ADDR_pi   = da;
        bus.D_WDATA_pi  = wd;
        bus.IF_REQ_pi   = ife;
        bus.D_REQ_pi    = de;
        if_pend    = ife;
        d_pend     = de;
        first_seen = 1'b0;
        n          = 0;
        while ((if_pend || d_pend) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (!first_seen && (bus.IF_DONE_po || bus.D_DONE_po)) begin
                first_seen = 1'b1;
                check("first_latency", 64'(n), 64'((first_dly < 0) ? TIMEOUT + 1 : first_dly + 2));
            end
            if (bus.IF_DONE_po && if_pend) begin
                if_pend        = 1'b0;
                bus.IF_REQ_pi  = 1'b0;
                bus.IF_ADDR_pi = $urandom;
            end
            if (bus.D_DONE_po && d_pend) begin
                d_pend         = 1'b0;
                bus.D_REQ_pi   = 1'b0;
                bus.D_ADDR_pi  = $urandom;
                bus.D_WDATA_pi = $urandom;
            end
        end
        if (if_pend || d_pend) begin
            check("batch_complete", 64'(1), 64'(0));
            bus.IF_REQ_pi = 1'b0;
            bus.D_REQ_pi  = 1'b0;
        end
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        #1;
    endtask

    function automatic int rand_dly();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return -1;
        if (r == 1) return TIMEOUT - 1;
        return $urandom_range(0, 4);
    endfunction

    // Memory responder: acks each access after the delay queued for it, random ack noise otherwise.
    initial begin : memory
        int   cnt;
        bit   act;
        mem_t cur;
        act = 1'b0;
        cnt = 0;
        cur.delay = -1;
        cur.rdata = '0;
        bus.MEM_ACK_pi   = 1'b0;
        bus.MEM_RDATA_pi = '0;
        forever begin
            @(negedge clk);
            if (rst || !bus.MEM_REQ_po) begin
                act = 1'b0;
                bus.MEM_ACK_pi   = ($urandom_range(0, 3) == 0);
                bus.MEM_RDATA_pi = $urandom;
            end else begin
                if (!act) begin
                    act = 1'b1;
                    cnt = 0;
                    if (mem_q.size() == 0) begin
                        cur.delay = -1;
                        cur.rdata = '0;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                if (cnt == cur.delay) begin
                    bus.MEM_ACK_pi   = 1'b1;
                    bus.MEM_RDATA_pi = cur.rdata;
                end else begin
                    bus.MEM_ACK_pi   = 1'b0;
                    bus.MEM_RDATA_pi = $urandom;
                end
                cnt++;
            end
        end
    end

    initial begin : monitor
        bit    act;
        int    len;
        attr_t a;
        done_t d;
        act = 1'b0;
        len = 0;
        a.len = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
            end else begin
                if (bus.MEM_REQ_po) begin
                    if (!act) begin
                        act = 1'b1;
                        len = 0;
                        if (attr_q.size() == 0) begin
                            check("unexpected_access", 64'(1), 64'(0));
                            a.len = -1;
                        end else begin
                            a = attr_q.pop_front();
                            check("mem_addr", 64'(bus.MEM_ADDR_po), 64'(a.addr));
                            check("mem_wdata", 64'(bus.MEM_WDATA_po), 64'(a.wdata));
                        end
                    end
                    len++;
                    if (a.len >= 0) check("mem_we", 64'(bus.MEM_WE_po), 64'(a.we));
                end else if (act) begin
                    act = 1'b0;
                    if (a.len >= 0) check("req_len", 64'(len), 64'(a.len));
                end

                if (bus.IF_DONE_po || bus.D_DONE_po) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 64'(1), 64'(0));
                    end else begin
                        d = done_q.pop_front();
                        check("done_owner", 64'({bus.IF_DONE_po, bus.D_DONE_po}), 64'({!d.own_ls, d.own_ls}));
                        check("if_rdata", 64'(bus.IF_RDATA_po), 64'(d.if_rdata));
                        check("d_rdata", 64'(bus.D_RDATA_po), 64'(d.d_rdata));
                        check("err", 64'(bus.ERR_po), 64'(d.err));
                    end
                end else if (bus.ERR_po) begin
                    check("err_without_done", 64'(1), 64'(0));
                end
                if (bus.IF_REQ_pi) check("if_stall", 64'(bus.IF_STALL_po), 64'(!bus.IF_DONE_po));
                if (bus.D_REQ_pi)  check("d_stall", 64'(bus.D_STALL_po), 64'(!bus.D_DONE_po));
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : stimulus
        attr_t a;
        mem_t  m;
        bus.IF_REQ_pi  = 1'b0;
        bus.IF_ADDR_pi = '0;
        bus.D_REQ_pi   = 1'b0;
        bus.D_WE_pi    = 1'b0;
        bus.D_ADDR_pi  = '0;
        bus.D_WDATA_pi = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(bus.MEM_REQ_po), 64'(0));
        check("rst_mem_attr", 64'({bus.MEM_WE_po, bus.MEM_ADDR_po, bus.MEM_WDATA_po}), 64'(0));
        check("rst_rdata", 64'({bus.IF_RDATA_po, bus.D_RDATA_po}), 64'(0));
        check("rst_flags", 64'({bus.IF_DONE_po, bus.D_DONE_po, bus.ERR_po, bus.IF_STALL_po, bus.D_STALL_po}), 64'(0));
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;

        run_batch(1, 0, 32'h40, 0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0);
        run_batch(0, 1, 32'h0, 0, 32'h200, 32'h0, 0, 32'h0, 1, 32'hCAFEF00D);
        run_batch(0, 1, 32'h0, 1, 32'h100, 32'h12345678, 0, 32'h0, 3, 32'h5555AAAA);
        for (int i = 0; i < 6; i++) begin
            run_batch(1, 1, 32'h1000 + 32'(i * 4), 0, 32'h2000 + 32'(i * 4), $urandom,
                      0, $urandom, 0, $urandom);
        end
        run_batch(1, 0, 32'h44, 0, 32'h0, 32'h0, -1, 32'h0, 0, 32'h0);
        run_batch(0, 1, 32'h0, 0, 32'h300, 32'h0, 0, 32'h0, -1, 32'h0);
        run_batch(1, 0, 32'h48, 0, 32'h0, 32'h0, TIMEOUT - 1, 32'hA5A5A5A5, 0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            run_batch(sel != 1, sel != 0, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                      rand_dly(), $urandom, rand_dly(), $urandom);
        end

        // Reset in the middle of a load that memory never acknowledges.
        a.we = 1'b0; a.addr = 32'h400; a.wdata = 32'h77; a.len = -1;
        m.delay = -1; m.rdata = '0;
        attr_q.push_back(a);
        mem_q.push_back(m);
        bus.D_WE_pi    = 1'b0;
        bus.D_ADDR_pi  = 32'h400;
        bus.D_WDATA_pi = 32'h77;
        bus.D_REQ_pi   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("busy_before_reset", 64'(bus.MEM_REQ_po), 64'(1));
        rst = 1'b1;
        bus.D_REQ_pi = 1'b0;
        #1;
        check("midrst_mem_req", 64'(bus.MEM_REQ_po), 64'(0));
        check("midrst_mem_attr", 64'({bus.MEM_WE_po, bus.MEM_ADDR_po, bus.MEM_WDATA_po}), 64'(0));
        check("midrst_rdata", 64'({bus.IF_RDATA_po, bus.D_RDATA_po}), 64'(0));
        check("midrst_flags", 64'({bus.IF_DONE_po, bus.D_DONE_po, bus.ERR_po, bus.IF_STALL_po, bus.D_STALL_po}), 64'(0));
        m_if_rdata = '0;
        m_d_rdata  = '0;
`ifdef ARB_ROUND_ROBIN_EN
        m_last_d   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        run_batch(1, 0, 32'h80, 0, 32'h0, 32'h0, 1, 32'h0BADF00D, 0, 32'h0);
        run_batch(1, 1, 32'h84, 0, 32'h500, 32'h0, 0, 32'h11112222, 2, 32'h33334444);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(done_q.size() + attr_q.size() + mem_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port unified memory between the processor's instruction-fetch stage and its load/store stage. It latches the winning request, drives it to memory with a hold-until-acknowledge handshake, returns read data and a one-cycle completion pulse to the owner, and exposes stall signals the pipeline uses to freeze. A watchdog aborts accesses the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles MEM_REQ_po waits for MEM_ACK_pi; 0 disables the watchdog
- CLK_pi  in  1  clock, all state on rising edge
- CPU_RESET_pi  in  1  asynchronous, active-high reset
- IF_REQ_pi  in  1  fetch request, held until IF_DONE_po
- IF_ADDR_pi  in  ADDR_W  fetch address, stable while IF_REQ_pi high
- IF_RDATA_po  out  DATA_W  fetched word, registered
- IF_DONE_po  out  1  one-cycle completion pulse to fetch
- IF_STALL_po  out  1  IF_REQ_pi & ~IF_DONE_po (combinational)
- D_REQ_pi  in  1  load/store request, held until D_DONE_po
- D_WE_pi  in  1  1 = store, 0 = load
- D_ADDR_pi  in  ADDR_W  data address
- D_WDATA_pi  in  DATA_W  store data
- D_RDATA_po  out  DATA_W  load result, registered
- D_DONE_po  out  1  one-cycle completion pulse to load/store
- D_STALL_po  out  1  D_REQ_pi & ~D_DONE_po (combinational)
- MEM_REQ_po  out  1  memory request, held until acknowledged
- MEM_WE_po, MEM_ADDR_po, MEM_WDATA_po  out  1/ADDR_W/DATA_W  latched access attributes
- MEM_RDATA_pi  in  DATA_W  read data, valid with MEM_ACK_pi
- MEM_ACK_pi  in  1  memory completes access at this edge
- ERR_po  out  1  pulses with DONE when the access timed out

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE: no request -> stay. Request(s) present -> pick winner, latch its address/WE/WDATA (WE forced 0 for fetch), go BUSY_IF or BUSY_D.
- BUSY_x: MEM_REQ_po = 1 with latched attributes. MEM_ACK_pi high at edge -> latch MEM_RDATA_pi into owner's RDATA (loads and fetches only; stores leave D_RDATA_po unchanged), go RESP.
- Watchdog: counter clears on entry to BUSY_x, increments each BUSY cycle without ack; reaching TIMEOUT -> go RESP with ERR flag set, owner's RDATA loaded with 0.
- RESP: owner's DONE_po = 1, ERR_po = ERR flag; all REQ inputs ignored; next state IDLE. Requesters update or drop REQ by the edge ending RESP.
- MEM_ACK_pi outside BUSY_x ignored. Ack and timeout at the same edge: ack wins, ERR_po = 0.

## Timing
- Reset (async, any state): state IDLE, all outputs 0, watchdog 0, round-robin pointer = "fetch served last". Reset mid-access abandons it; MEM_REQ_po drops immediately.
- Request sampled in IDLE at edge N -> MEM_REQ_po high cycle N+1. Ack sampled at edge N+1+k -> DONE_po high for exactly one cycle after it. Minimum request-to-DONE: 2 edges (k = 0); one access per 3+k cycles.
- Timeout: MEM_REQ_po high for exactly TIMEOUT cycles, then RESP.
- STALL outputs low in the DONE cycle so the stage advances exactly once.

## Configuration
- ARB_ROUND_ROBIN_EN defined: simultaneous requests go to the requester not served last; pointer updates on entry to BUSY_x. Single request always wins.
- Undefined: fixed priority, data beats fetch; pointer not implemented. Continuous data requests may starve fetch (accepted: pipeline blocks fetch during D stalls).

## Test plan
- Single fetch, IF_ADDR_pi=0x40, memory acks first BUSY cycle with 0xDEADBEEF -> MEM_REQ_po one cycle, IF_RDATA_po=0xDEADBEEF, IF_DONE_po one pulse 2 edges after request, ERR_po=0.
- Store D_ADDR_pi=0x100, D_WDATA_pi=0x12345678, ack after 3 wait cycles -> MEM_WE_po=1 held 4 cycles, D_DONE_po pulse, D_RDATA_po unchanged.
- Both request every cycle from reset, ack immediately: with ARB_ROUND_ROBIN_EN grants alternate D,IF,D,IF; without, D only while D_REQ_pi high.
- No ack, TIMEOUT=15 -> MEM_REQ_po high exactly 15 cycles, DONE and ERR_po pulse together, RDATA=0; ack and timeout coincident -> ERR_po=0.
- CPU_RESET_pi asserted mid-BUSY_D -> MEM_REQ_po and all outputs 0 immediately; after release, a new fetch completes normally.
